frame_ram_arbiter: RTL and testbench
====================================

# frame_ram_arbiter

Shares the single-port frame RAM between the VGA display reader (read requester) and the serial pixel writer (write requester) in the VGA serial display design. Sits between both requesters and the RAM port: the reader is served with fixed priority so scan-out never stalls, and the writer is served in idle slots. With the starvation guard compiled in, the writer also gets a forced slot after a bounded run of reads. Registered RAM-side outputs; 2-cycle read latency from grant to data.

## Interface

- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 17, RAM address width
- MAX_ADDR, 129599, highest legal word address
- STARVE_LIMIT, 8, consecutive read grants with writer pending before a forced write slot (guard only)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rd_req  in  1  reader requests a word
- rd_addr  in  ADDR_WIDTH  read address
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_valid  out  1  rd_data valid, single-cycle pulse
- rd_data  out  DATA_WIDTH  read word
- wr_req  in  1  writer requests a store
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write word
- wr_gnt  out  1  write accepted this cycle (combinational)
- wr_err  out  1  pulse: accepted write had wr_addr > MAX_ADDR, dropped
- ram_addr  out  ADDR_WIDTH  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  DATA_WIDTH  RAM write data (registered)
- ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_addr

## Operation

- Handshake: requester holds req/addr/data stable until it samples gnt high; transfer occurs on the cycle req && gnt. At most one gnt high per cycle.
- States: IDLE (no grant last cycle), RD (read granted last cycle), WR (write granted last cycle).
- Default priority: rd_req wins; wr_gnt = wr_req && !rd_req.
- Transitions: any state → RD on read grant; → WR on write grant; → IDLE when neither is granted.
- Starvation counter (guard only): increments on each read grant while wr_req is high; saturates at STARVE_LIMIT. Clears on write grant or when wr_req is low. When count == STARVE_LIMIT and wr_req is high: writer granted, reader gets rd_gnt=0 that cycle.
- Write grant: next edge drives ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data. If wr_addr > MAX_ADDR, ram_we stays 0 and wr_err pulses 1 cycle after the grant.
- Read grant: next edge drives ram_we=0, ram_addr=rd_addr. A 2-stage valid pipeline tags the request. rd_data=ram_rdata is registered, and rd_valid pulses 2 cycles after grant. Out-of-range rd_addr is clamped to MAX_ADDR.
- Back-to-back reads are fully pipelined: 1 word per cycle.
- No grant: ram_we=0, ram_addr holds.

## Timing

- Reset values: rd_valid=0, rd_data=0, wr_err=0, ram_we=0, ram_addr=0, ram_wdata=0, state=IDLE, counter=0. rd_gnt/wr_gnt follow inputs combinationally but are forced 0 while rst is low.
- Read latency: grant in cycle N → rd_valid/rd_data in cycle N+2.
- Write: grant in cycle N → RAM write at the end of cycle N+1.
- Simultaneous rd_req && wr_req: reader granted, unless the guard forces the writer.
- Reset mid-operation: in-flight reads are discarded (no rd_valid), pending writes are lost, and the counter clears.

## Configuration

- FRAME_ARB_STARVE_GUARD_EN defined: starvation counter and forced write slot present. Writer wait is bounded to STARVE_LIMIT+1 cycles.
- Undefined: strict reader priority; no counter logic. The writer can wait indefinitely during continuous reads.

## Structure

- Shared package frame_ram_pkg: arb_state_t enum {IDLE, RD, WR}, FRAME_MAX_ADDR=129599, FRAME_ADDR_WIDTH=17.
- One sub-module: frame_arb_read_pipe (2-stage valid/data pipeline for the read return path).

## Test plan

- Reset with rd_req=1, rd_addr=5 → all outputs 0. After release, rd_gnt=1, and rd_valid pulses 2 cycles later with the RAM content at address 5.
- Reads to 0,1,2,3 on consecutive cycles → rd_valid high for 4 consecutive cycles, data in order, ram_we never 1.
- wr_req=1, wr_addr=100, wr_data=0xDEADBEEF, rd_req=0 → wr_gnt same cycle; the next cycle shows ram_we=1, ram_addr=100; a later read of 100 returns 0xDEADBEEF.
- wr_addr=129600 accepted → ram_we stays 0, wr_err pulses once.
- Continuous rd_req with wr_req held, guard defined and STARVE_LIMIT=8 → wr_gnt after exactly 8 read grants, with rd_gnt=0 that cycle. Guard undefined → wr_gnt never asserts.
- rst asserted 1 cycle after a read grant → no rd_valid. After release, the counter is 0 and the state is IDLE.

Source files
------------

// File: rtl/frame_ram_pkg.sv
// Shared definitions for the frame RAM arbiter slice.
//
// Contents:
//   FRAME_ADDR_WIDTH   - word address width of the frame RAM
//   FRAME_DATA_WIDTH   - word width of the frame RAM
//   FRAME_MAX_ADDR     - highest legal word address (one 360x360 frame)
//   FRAME_STARVE_LIMIT - default read-run length before the writer is forced in
//   arb_state_t        - arbiter state: what was granted in the previous cycle
package frame_ram_pkg;

  localparam int FRAME_ADDR_WIDTH   = 17;
  localparam int FRAME_DATA_WIDTH   = 32;
  localparam int FRAME_MAX_ADDR     = 129599;
  localparam int FRAME_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing granted last cycle
    RD   = 2'd1,  // read granted last cycle
    WR   = 2'd2   // write granted last cycle
  } arb_state_t;

endpackage

// File: rtl/frame_arb_read_pipe.sv
// Read return path of the frame RAM arbiter.
//
// A read granted in cycle N has its address on the RAM in cycle N+1; the RAM
// word is captured at the end of N+1 and presented, with a one-cycle
// rd_valid pulse, in cycle N+2. Reset discards anything in flight.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   rd_fire   in   read granted this cycle
//   ram_rdata in   RAM read word for the address issued last cycle
//   rd_valid  out  rd_data valid, single-cycle pulse
//   rd_data   out  registered read word
module frame_arb_read_pipe
  import frame_ram_pkg::*;
#(
  parameter int DATA_WIDTH = FRAME_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_fire,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Stage 1: the RAM address for this read is on the bus this cycle.
  logic issued;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      issued   <= rd_fire;
      rd_valid <= issued;
      if (issued) rd_data <= ram_rdata;
    end
  end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Single-port frame RAM arbiter: VGA reader vs. serial pixel writer.
//
// The reader has fixed priority so scan-out never stalls; the writer takes
// idle slots. Grants are combinational; all RAM-side outputs are registered.
// Read data returns two cycles after the grant; reads pipeline at one word
// per cycle. Out-of-range read addresses are clamped to MAX_ADDR; out-of-range
// writes are dropped and flagged on wr_err one cycle after the grant.
//
// Configuration macro FRAME_ARB_STARVE_GUARD_EN: when defined, a counter of
// consecutive read grants taken while the writer waits forces a write slot
// once it reaches STARVE_LIMIT. When undefined the reader has strict priority.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   rd_req, rd_addr            reader request / address
//   rd_gnt                     read accepted this cycle
//   rd_valid, rd_data          read return, two cycles after rd_gnt
//   wr_req, wr_addr, wr_data   writer request / address / word
//   wr_gnt                     write accepted this cycle
//   wr_err                     pulse: accepted write was out of range, dropped
//   ram_addr, ram_we, ram_wdata  registered RAM port
//   ram_rdata                  RAM read word, valid the cycle after ram_addr
module frame_ram_arbiter
  import frame_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = FRAME_DATA_WIDTH,
  parameter int ADDR_WIDTH   = FRAME_ADDR_WIDTH,
  parameter int MAX_ADDR     = FRAME_MAX_ADDR,
  parameter int STARVE_LIMIT = FRAME_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  output logic                  wr_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(MAX_ADDR);

  arb_state_t            state, next_state;
  logic                  force_wr;
  logic                  wr_in_range;
  logic [ADDR_WIDTH-1:0] rd_addr_clamped;

  assign wr_in_range     = (wr_addr <= MAX_A);
  assign rd_addr_clamped = (rd_addr > MAX_A) ? MAX_A : rd_addr;

`ifdef FRAME_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Read grants taken back-to-back while the writer is waiting.
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (wr_gnt || !wr_req) begin
      starve_cnt <= '0;
    end else if (rd_gnt && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_wr = wr_req && (starve_cnt == LIMIT);
`else
  assign force_wr = 1'b0;
`endif

  // Grants are held low during reset so neither requester sees a phantom
  // handshake while the RAM-side registers are cleared.
  // NOTE: every always_comb output is assigned a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (rst) begin
      rd_gnt = rd_req && !force_wr;
      wr_gnt = wr_req && (!rd_req || force_wr);
    end
  end

  // State records what was granted in the previous cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    if (rd_gnt)      next_state = RD;
    else if (wr_gnt) next_state = WR;
  end

  // RAM port registers. On an idle cycle the address holds and only the
  // write enable drops; an out-of-range write leaves address and data alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (rd_gnt) begin
      ram_we   <= 1'b0;
      ram_addr <= rd_addr_clamped;
    end else if (wr_gnt) begin
      ram_we <= wr_in_range;
      if (wr_in_range) begin
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
      end
    end else begin
      ram_we <= 1'b0;
    end
  end

  // A write granted last cycle that did not raise ram_we was out of range.
  assign wr_err = (state == WR) && !ram_we;

  frame_arb_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_read_pipe (
    .clk       (clk),
    .rst       (rst),
    .rd_fire   (rd_gnt),
    .ram_rdata (ram_rdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Self-checking bench for frame_ram_arbiter. A behavioural RAM sits on the
// RAM port. An observer pushes expected read returns / write errors into
// queues when it sees a grant; a monitor pops and compares them when the DUT
// presents rd_valid / wr_err. Directed phases check grants and RAM outputs.
module tb_frame_ram_arbiter;
  import frame_ram_pkg::*;

  localparam int DW = 32;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_gnt, wr_gnt, rd_valid, wr_err, ram_we;
  logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  frame_ram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .wr_err    (wr_err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // ---------------- behavioural RAM ----------------
  function automatic logic [DW-1:0] pat(input int a);
    return 32'hA5A5_0000 ^ 32'(a);
  endfunction

  logic [DW-1:0] mem   [0:131071];
  bit            wrote [0:131071];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]   <= ram_wdata;
      wrote[ram_addr] <= 1'b1;
    end
  end

  assign ram_rdata = wrote[ram_addr] ? mem[ram_addr] : pat(int'(ram_addr));

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  rd_exp_t       rd_q [$];
  int            err_q [$];
  logic [DW-1:0] shadow [int];

  function automatic logic [DW-1:0] exp_word(input int a);
    return shadow.exists(a) ? shadow[a] : pat(a);
  endfunction

  // Observer: turns each handshake into an expected future response.
  always @(negedge clk) begin
    if (rd_req && rd_gnt) begin
      int a;
      a = (int'(rd_addr) > FRAME_MAX_ADDR) ? FRAME_MAX_ADDR : int'(rd_addr);
      rd_q.push_back('{data: exp_word(a), due: cyc + 2});
    end
    if (wr_req && wr_gnt) begin
      if (int'(wr_addr) > FRAME_MAX_ADDR) err_q.push_back(cyc + 1);
      else                                shadow[int'(wr_addr)] = wr_data;
    end
  end

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (rd_q.size() == 0) begin
        check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check("rd_latency", 32'(cyc), 32'(e.due));
        check("rd_data", rd_data, e.data);
      end
    end
    if (wr_err) begin
      if (err_q.size() == 0) begin
        check("unexpected_wr_err", 32'(wr_err), 32'd0);
      end else begin
        int due;
        due = err_q.pop_front();
        check("wr_err_latency", 32'(cyc), 32'(due));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_one(input logic [AW-1:0] a);
    rd_req  = 1'b1;
    rd_addr = a;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_gnt) break;
    end
    check("read_one_gnt", 32'(rd_gnt), 32'd1);
    tick();
    rd_req = 1'b0;
  endtask

  // Reader and writer both request continuously; count read grants until
  // the writer gets in (or a budget of cycles expires).
  task automatic run_starve(input string tag);
    int nrd;
    bit got;
    nrd     = 0;
    got     = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 17'd20;
    wr_req  = 1'b1;
    wr_addr = 17'd200;
    wr_data = 32'h1234_5678;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (wr_gnt) begin
        got = 1'b1;
        check({tag, "_rd_gnt_low"}, 32'(rd_gnt), 32'd0);
        check({tag, "_reads_before_wr"}, 32'(nrd), 32'd8);
      end else if (rd_gnt) begin
        nrd++;
      end
      tick();
      if (got) wr_req = 1'b0;
    end
`ifdef FRAME_ARB_STARVE_GUARD_EN
    check({tag, "_wr_granted"}, 32'(got), 32'd1);
    rd_req = 1'b0;
`else
    check({tag, "_wr_never"}, 32'(got), 32'd0);
    rd_req = 1'b0;
    @(negedge clk);
    check({tag, "_wr_after_reads"}, 32'(wr_gnt), 32'd1);
    tick();
    wr_req = 1'b0;
`endif
    repeat (3) tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst     = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 17'd5;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // Reset holds everything at zero even with a request pending.
    repeat (2) @(negedge clk);
    check("rst_rd_gnt", 32'(rd_gnt), 32'd0);
    check("rst_wr_gnt", 32'(wr_gnt), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);

    tick();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_rd_gnt", 32'(rd_gnt), 32'd1);
    tick();
    rd_req = 1'b0;
    repeat (3) tick();

    // Four back-to-back reads: one grant per cycle, never a write.
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(i);
      @(negedge clk);
      check("burst_rd_gnt", 32'(rd_gnt), 32'd1);
      check("burst_ram_we", 32'(ram_we), 32'd0);
      tick();
    end
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("burst_drain_ram_we", 32'(ram_we), 32'd0);
    end

    // In-range write, then read it back.
    tick();
    wr_req  = 1'b1;
    wr_addr = 17'd100;
    wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_gnt_same_cycle", 32'(wr_gnt), 32'd1);
    tick();
    wr_req = 1'b0;
    @(negedge clk);
    check("wr_ram_we", 32'(ram_we), 32'd1);
    check("wr_ram_addr", 32'(ram_addr), 32'd100);
    check("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    tick();
    read_one(17'd100);
    repeat (3) tick();

    // Out-of-range write: accepted, dropped, flagged once.
    wr_req  = 1'b1;
    wr_addr = 17'd129600;
    wr_data = 32'h0BAD_0BAD;
    @(negedge clk);
    check("bad_wr_gnt", 32'(wr_gnt), 32'd1);
    tick();
    wr_req = 1'b0;
    @(negedge clk);
    check("bad_wr_ram_we", 32'(ram_we), 32'd0);
    check("bad_wr_err", 32'(wr_err), 32'd1);
    @(negedge clk);
    check("bad_wr_err_once", 32'(wr_err), 32'd0);
    tick();

    // Out-of-range read is clamped to the last frame word.
    read_one(17'h1FFFF);
    @(negedge clk);
    check("clamp_ram_addr", 32'(ram_addr), 32'(FRAME_MAX_ADDR));
    repeat (4) tick();

    // Contention with the writer held pending.
    run_starve("starve1");

    // Reset one cycle after a read grant, with the counter part-way up.
    rd_req  = 1'b1;
    rd_addr = 17'd9;
    wr_req  = 1'b1;
    wr_addr = 17'd300;
    wr_data = 32'h5555_AAAA;
    repeat (3) begin
      @(negedge clk);
      tick();
    end
    rst    = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b0;
    rd_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_rd_valid", 32'(rd_valid), 32'd0);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state_idle", 32'(dut.state), 32'(IDLE));
    tick();

    // Counter must restart from zero after reset.
    run_starve("starve2");

    repeat (4) tick();
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("err_queue_drained", 32'(err_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
